// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline control path.
package pipe_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DWAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0]  REG_X0 = 5'd0;
    localparam logic [31:0] NOP    = 32'h00000013;  // addi x0, x0, 0

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirects and
// data-memory waits, with a redirect held across a wait and performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             use_rs2D,
    input  logic [4:0]       rdE,
    input  logic             mem_readE,
    input  logic             redirectE,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             stallD,
    output logic             flushD,
    output logic             stallE,
    output logic             flushE,
    output logic             stallM,
    output logic             redirect_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    hz_state_t   state;
    logic        pend_redir;
    logic [15:0] wait_cnt;
    logic [15:0] wait_nxt;
    logic        lu;
    logic        dw;
    logic        redir_now;

    assign lu = mem_readE && (rdE != REG_X0) &&
                ((rdE == rs1D) || (use_rs2D && (rdE == rs2D)));
    assign dw = dmem_req && !dmem_ready;
    // A redirect held through a wait replays on the release cycle.
    assign redir_now = redirectE || ((state == ST_DWAIT) && pend_redir);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_en        = 1'b1;
        stallD       = 1'b0;
        flushD       = 1'b0;
        stallE       = 1'b0;
        flushE       = 1'b0;
        stallM       = 1'b0;
        redirect_sel = 1'b0;
        wait_nxt     = 16'd1;
        if (state == ST_DWAIT)
            wait_nxt = (wait_cnt >= TMO) ? wait_cnt : wait_cnt + 16'd1;
        if (!rst) begin
            if (dw) begin
                pc_en  = 1'b0;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
            end else if (redir_now) begin
                // The ID instruction is squashed, so a coincident load-use is moot.
                redirect_sel = 1'b1;
                flushD       = 1'b1;
                flushE       = 1'b1;
            end else if (lu) begin
                pc_en  = 1'b0;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state       <= ST_RUN;
            pend_redir  <= 1'b0;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else if (dw) begin
            state      <= ST_DWAIT;
            pend_redir <= pend_redir || redirectE;
            wait_cnt   <= wait_nxt;
            if (wait_nxt == TMO)
                mem_timeout <= 1'b1;
        end else begin
            state      <= ST_RUN;
            pend_redir <= 1'b0;
            wait_cnt   <= 16'd0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flushD),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: expected control vectors are queued as
// stimulus is applied and compared against the outputs sampled in that cycle.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    // {pc_en, stallD, flushD, stallE, flushE, stallM, redirect_sel}
    localparam logic [6:0] O_IDLE = 7'b1000000;
    localparam logic [6:0] O_LU   = 7'b0100100;
    localparam logic [6:0] O_FRZ  = 7'b0101010;
    localparam logic [6:0] O_RED  = 7'b1010101;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1D, rs2D, rdE;
    logic             use_rs2D, mem_readE, redirectE, dmem_req, dmem_ready;
    logic             pc_en, stallD, flushD, stallE, flushE, stallM, redirect_sel;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [6:0] exp_q[$];
    logic [6:0] obs_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(3), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1D         (rs1D),
        .rs2D         (rs2D),
        .use_rs2D     (use_rs2D),
        .rdE          (rdE),
        .mem_readE    (mem_readE),
        .redirectE    (redirectE),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .stallD       (stallD),
        .flushD       (flushD),
        .stallE       (stallE),
        .flushE       (flushE),
        .stallM       (stallM),
        .redirect_sel (redirect_sel),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    function automatic logic [6:0] outs();
        return {pc_en, stallD, flushD, stallE, flushE, stallM, redirect_sel};
    endfunction

    // Drive one cycle of inputs at negedge, queue the expected controls, and
    // capture what the DUT shows for that cycle.
    task automatic apply(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic red,
                         input logic req, input logic rdy, input logic [6:0] e);
        @(negedge clk);
        rs1D = rs1; rs2D = rs2; use_rs2D = u2; rdE = rd;
        mem_readE = mr; redirectE = red; dmem_req = req; dmem_ready = rdy;
        exp_q.push_back(e);
        #1;
        obs_q.push_back(outs());
    endtask

    task automatic idle(input logic [6:0] e);
        apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        rs1D = '0; rs2D = '0; use_rs2D = 0; rdE = '0;
        mem_readE = 0; redirectE = 0; dmem_req = 0; dmem_ready = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] e, o;
        @(negedge clk);
        rst = 1'b1;
        rs1D = 5'd5; rs2D = '0; use_rs2D = 0; rdE = 5'd5;
        mem_readE = 1; redirectE = 1; dmem_req = 1; dmem_ready = 0;
        exp_q.push_back(O_IDLE);
        #1;
        obs_q.push_back(outs());
        @(posedge clk); #1;
        n_checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state stall_cnt=%0d flush_cnt=%0d tmo=%b required 0/0/0",
                     stall_cnt, flush_cnt, mem_timeout);
        end
        reset_dut();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL reset_outputs got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_load_use();
        logic [6:0] e, o;
        reset_dut();
        apply(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        idle(O_IDLE);
        n_checks++;
        if (stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL lu_stall_cnt got %0d required 1", stall_cnt);
        end
        apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
        idle(O_IDLE);
        n_checks++;
        if (stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL lu_x0_stall_cnt got %0d required 1", stall_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL load_use got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_rs2_gate();
        logic [6:0] e, o;
        reset_dut();
        apply(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
        apply(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        idle(O_IDLE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL rs2_gate got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_branch_lu();
        logic [6:0] e, o;
        reset_dut();
        apply(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_RED);
        idle(O_IDLE);
        n_checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL branch_lu_cnt flush=%0d stall=%0d required 1/0", flush_cnt, stall_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL branch_lu got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] e, o;
        reset_dut();
        for (int i = 0; i < 4; i++)
            apply(5'd0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);
        apply(5'd0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, O_RED);
        idle(O_IDLE);
        n_checks++;
        if (stall_cnt !== 32'd4 || flush_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL mem_wait_cnt stall=%0d flush=%0d required 4/1", stall_cnt, flush_cnt);
        end
        idle(O_IDLE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL mem_wait got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e, o;
        reset_dut();
        apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ);
        apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_IDLE);
        apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ);
        apply(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, O_LU);
        idle(O_IDLE);
        n_checks++;
        if (stall_cnt !== 32'd3 || flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_cnt stall=%0d flush=%0d required 3/0", stall_cnt, flush_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL back_to_back got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [6:0] e, o;
        reset_dut();
        for (int i = 1; i <= 5; i++) begin
            apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ);
            n_checks++;
            if (mem_timeout !== (i >= 4)) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d got %b required %b", i, mem_timeout, i >= 4);
            end
        end
        apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_IDLE);
        idle(O_IDLE);
        n_checks++;
        if (mem_timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky got %b required 1", mem_timeout);
        end
        reset_dut();
        #1;
        n_checks++;
        if (mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear got %b required 0", mem_timeout);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL timeout_ctrl got %b required %b", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [6:0] e, o;
        reset_dut();
        apply(5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);
        apply(5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(O_IDLE);
        #1;
        obs_q.push_back(outs());
        @(negedge clk);
        rst = 1'b0;
        dmem_req = 1'b1; dmem_ready = 1'b1; redirectE = 1'b0;
        exp_q.push_back(O_IDLE);
        #1;
        obs_q.push_back(outs());
        n_checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_rst stall=%0d flush=%0d tmo=%b required 0/0/0",
                     stall_cnt, flush_cnt, mem_timeout);
        end
        idle(O_IDLE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL reset_mid_wait got %b required %b", o, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rs1D = '0; rs2D = '0; use_rs2D = 0; rdE = '0;
        mem_readE = 0; redirectE = 0; dmem_req = 0; dmem_ready = 0;
        test_reset();
        test_load_use();
        test_rs2_gate();
        test_branch_lu();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
